// File: rtl/truth_table_extractor.sv
// Sweeps all eight input vectors of a 3-input gate, samples its output and
// rebuilds the gate's hex code, flagging vectors whose output was not steady.
module truth_table_extractor #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic [7:0] unstable,
  output logic       match
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [2:0]    pos;
  logic [CW-1:0] cnt;
  logic [7:0]    exp_q;
  logic [7:0]    tc_nxt;
  logic [7:0]    un_nxt;

  assign {in1, in2, in3} = idx;
  // Vector 000 lands in bit 7, so the bit position is the complement of idx.
  assign pos = ~idx;

  // Result of the current sample cycle; the final one also feeds match.
  always_comb begin
    tc_nxt = table_code;
    un_nxt = unstable;
    if (cnt == '0) begin
      tc_nxt[pos] = dut_out;
    end else if (dut_out != table_code[pos]) begin
      un_nxt[pos] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      exp_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_code <= '0;
      unstable   <= '0;
      match      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            exp_q      <= expected;
            table_code <= '0;
            unstable   <= '0;
            match      <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            if (SETTLE_CYCLES == 0) state <= SAMPLE;
            else                    state <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            table_code <= '0;
            unstable   <= '0;
            match      <= 1'b0;
          end else if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            table_code <= '0;
            unstable   <= '0;
            match      <= 1'b0;
          end else begin
            table_code <= tc_nxt;
            unstable   <= un_nxt;
            if (cnt == SAMPLE_LAST) begin
              cnt <= '0;
              if (idx == 3'd7) begin
                // Match is taken from the post-sample values so it is valid alongside done.
                state <= DONE;
                idx   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                match <= (tc_nxt == exp_q) && (un_nxt == '0);
              end else begin
                idx <= idx + 3'd1;
                if (SETTLE_CYCLES == 0) state <= SAMPLE;
                else                    state <= SETTLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
